// File: rtl/traffic_phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer_if
// Operand/result bus between the phase sequencer and the 4-bit ripple adder.
//   elapsed : sequencer -> adder, operand A (registered elapsed-tick count)
//   incr    : sequencer -> adder, operand B (1 on a counted tick, else 0)
//   sum_in  : adder -> sequencer, elapsed + incr with the carry discarded
// Modports: master = sequencer side, slave = adder side.
// -----------------------------------------------------------------------------
interface traffic_phase_sequencer_if;
  logic [3:0] elapsed;
  logic [3:0] incr;
  logic [3:0] sum_in;

  modport master (output elapsed, output incr, input sum_in);
  modport slave  (input elapsed, input incr, output sum_in);
endinterface

// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
// Six-phase NS/EW traffic light controller. It keeps the elapsed-tick count of
// the current phase, hands it to an external adder as operand A and takes the
// adder's sum back as the next count. The phase advances when the phase
// duration expires, or early out of a green once a pedestrian request is
// pending and the minimum green time has been served.
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   tick        one-cycle time-base strobe
//   hold        freeze counting and phase changes while high
//   ped_req     pedestrian request pulse
//   adder       operand/result bus to the ripple adder (master side)
//   phase       current phase, 0..5
//   ns_*/ew_*   lamp drives decoded from the phase register
//   ped_pending latched, not yet served pedestrian request
//   phase_done  one-cycle pulse the cycle after every phase change
// -----------------------------------------------------------------------------
module traffic_phase_sequencer #(
  parameter int GREEN_T   = 9,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int MIN_GREEN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       hold,
  input  logic                       ped_req,
  traffic_phase_sequencer_if.master  adder,
  output logic [2:0]                 phase,
  output logic                       ns_r,
  output logic                       ns_y,
  output logic                       ns_g,
  output logic                       ew_r,
  output logic                       ew_y,
  output logic                       ew_g,
  output logic                       ped_pending,
  output logic                       phase_done
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_e;

  // Count value at which the final tick of each phase is sampled.
  localparam logic [3:0] GREEN_LAST  = 4'(GREEN_T - 1);
  localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_T - 1);
  localparam logic [3:0] ALLRED_LAST = 4'(ALLRED_T - 1);
  localparam logic [3:0] MIN_LAST    = 4'(MIN_GREEN - 1);

  phase_e     phase_q, phase_d;
  logic [3:0] elapsed_q, elapsed_d;
  logic       ped_q, ped_d;
  logic       done_q, done_d;

  logic       run;
  logic       is_green;
  logic       early;
  logic       adv;
  logic [3:0] last_tick;

  assign run           = tick & ~hold;
  assign adder.elapsed = elapsed_q;
  assign adder.incr    = run ? 4'd1 : 4'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= NS_GREEN;
      elapsed_q <= 4'd0;
      ped_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      elapsed_q <= elapsed_d;
      ped_q     <= ped_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    elapsed_d = elapsed_q;
    ped_d     = ped_q;
    done_d    = 1'b0;
    last_tick = GREEN_LAST;
    is_green  = 1'b0;

    case (phase_q)
      NS_GREEN, EW_GREEN: begin
        last_tick = GREEN_LAST;
        is_green  = 1'b1;
      end
      NS_YELLOW, EW_YELLOW: last_tick = YELLOW_LAST;
      ALLRED_A, ALLRED_B:   last_tick = ALLRED_LAST;
      default:              last_tick = GREEN_LAST;
    endcase

    // A pending pedestrian request shortens green, but never below MIN_GREEN.
    early = ped_q & is_green & (elapsed_q >= MIN_LAST);
    adv   = run & ((elapsed_q == last_tick) | early);

    if (phase_q > ALLRED_B) begin
      // Encodings 6/7 are unreachable in normal operation; recover cleanly.
      phase_d   = NS_GREEN;
      elapsed_d = 4'd0;
      done_d    = 1'b1;
    end else if (adv) begin
      case (phase_q)
        NS_GREEN:  phase_d = NS_YELLOW;
        NS_YELLOW: phase_d = ALLRED_A;
        ALLRED_A:  phase_d = EW_GREEN;
        EW_GREEN:  phase_d = EW_YELLOW;
        EW_YELLOW: phase_d = ALLRED_B;
        default:   phase_d = NS_GREEN;
      endcase
      elapsed_d = 4'd0;
      done_d    = 1'b1;
    end else if (run) begin
      elapsed_d = adder.sum_in;
    end

    // Entering yellow serves the request; a new request on the same edge wins
    // so that it carries over into the next green.
    if (adv && (phase_d == NS_YELLOW || phase_d == EW_YELLOW)) begin
      ped_d = 1'b0;
    end
    if (ped_req) begin
      ped_d = 1'b1;
    end
  end

  always_comb begin
    ns_r = 1'b0;
    ns_y = 1'b0;
    ns_g = 1'b0;
    ew_r = 1'b0;
    ew_y = 1'b0;
    ew_g = 1'b0;
    case (phase_q)
      NS_GREEN:  begin ns_g = 1'b1; ew_r = 1'b1; end
      NS_YELLOW: begin ns_y = 1'b1; ew_r = 1'b1; end
      ALLRED_A:  begin ns_r = 1'b1; ew_r = 1'b1; end
      EW_GREEN:  begin ns_r = 1'b1; ew_g = 1'b1; end
      EW_YELLOW: begin ns_r = 1'b1; ew_y = 1'b1; end
      default:   begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
  end

  assign phase       = phase_q;
  assign ped_pending = ped_q;
  assign phase_done  = done_q;

endmodule
